// File: rtl/i2s_clk_pkg.sv
// Shared defaults for the I2S transmit clock generator: divider exponents,
// counter widths and the push-button debounce time.
package i2s_clk_pkg;

    localparam int MCLK_LOG2_DEF       = 3;
    localparam int SCLK_LOG2_DEF       = 5;
    localparam int LRCLK_LOG2_DEF      = 11;
    localparam int CNT_W_DEF           = LRCLK_LOG2_DEF;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    function automatic int dbc_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int DBC_W_DEF = dbc_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/i2s_clk_top_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a debouncer.
// A new level is accepted only after the synchronized input has disagreed
// with the stable level for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce
    import i2s_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_stable
);

    localparam int                DBC_W    = dbc_width(DEBOUNCE_CYCLES);
    localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBC_W-1:0]  DBC_ONE  = DBC_W'(1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [DBC_W-1:0] dbc_cnt_q, dbc_cnt_d;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        stable_d  = stable_q;
        dbc_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (dbc_cnt_q == DBC_LAST) begin
                stable_d = sync2_q;
            end else begin
                dbc_cnt_d = dbc_cnt_q + DBC_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            stable_q  <= 1'b0;
            dbc_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            dbc_cnt_q <= dbc_cnt_d;
        end
    end

    assign btn_stable = stable_q;

endmodule

// File: rtl/i2s_clk_top.sv
// I2S transmit clock generator. One free-running counter produces MCLK,
// SCLK and LRCLK as direct register taps, so all three are glitch-free and
// every LRCLK edge lands on an SCLK falling edge.
// Build option: define BTN_TOGGLE_EN to make each accepted press toggle the
// clocks on/off; by default the clocks run only while the button is held.
module i2s_clk_top
    import i2s_clk_pkg::*;
#(
    parameter int MCLK_LOG2       = MCLK_LOG2_DEF,
    parameter int SCLK_LOG2       = SCLK_LOG2_DEF,
    parameter int LRCLK_LOG2      = LRCLK_LOG2_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic tx_mclk,
    output logic tx_sclk,
    output logic tx_lrclk
);

    if (!(MCLK_LOG2 >= 1 && MCLK_LOG2 < SCLK_LOG2 && SCLK_LOG2 < LRCLK_LOG2)) begin : g_bad_div
        $error("i2s_clk_top: divider exponents must satisfy 1 <= MCLK_LOG2 < SCLK_LOG2 < LRCLK_LOG2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_dbc
        $error("i2s_clk_top: DEBOUNCE_CYCLES must be at least 2");
    end

    localparam int               CNT_W   = LRCLK_LOG2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             btn_stable;
    logic             en;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dbc (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn),
        .btn_stable (btn_stable)
    );

`ifdef BTN_TOGGLE_EN
    logic en_q, en_d;
    logic stable_prev_q;

    // Flip the enable on each accepted press; releases are ignored.
    always_comb begin
        en_d = en_q ^ (btn_stable & ~stable_prev_q);
    end

    // Enable and press-edge history registers.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            en_q          <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            en_q          <= en_d;
            stable_prev_q <= btn_stable;
        end
    end

    assign en = en_q;
`else
    assign en = btn_stable;
`endif

    // Count while enabled, otherwise park at zero so restarts are phase-clean.
    always_comb begin
        cnt_d = en ? (cnt_q + CNT_ONE) : '0;
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tx_mclk  = cnt_q[MCLK_LOG2-1];
    assign tx_sclk  = cnt_q[SCLK_LOG2-1];
    assign tx_lrclk = cnt_q[LRCLK_LOG2-1];

endmodule

// File: tb/tb_i2s_clk_top.sv
// Self-checking bench for i2s_clk_top with a short debounce time.
// The reference model tracks the debounced level and a running clk count,
// and derives the expected clocks arithmetically from that count.
module tb_i2s_clk_top;

    localparam int DBC   = 100;
    localparam int FRAME = 2048;
`ifdef BTN_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic btn = 1'b0;
    logic tx_mclk, tx_sclk, tx_lrclk;

    i2s_clk_top #(
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn      (btn),
        .tx_mclk  (tx_mclk),
        .tx_sclk  (tx_sclk),
        .tx_lrclk (tx_lrclk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_s1 = 0, m_s2 = 0, m_stable = 0, m_prev = 0, m_en = 0;
    int m_run = 0;
    int m_n = 0;      // clks elapsed since counting (re)started
    bit st_old, rise;

    function automatic logic [2:0] exp_clocks(input int n);
        logic l, s, m;
        m = (n % 8) >= 4;
        s = (n % 32) >= 16;
        l = (n % FRAME) >= (FRAME / 2);
        return {l, s, m};
    endfunction

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0; m_en = 0;
            m_run = 0; m_n = 0;
        end else begin
            st_old = m_stable;
            rise   = m_stable & ~m_prev;
            // Stable level flips after DBC consecutive disagreeing clocks.
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DBC) begin
                    m_stable = m_s2;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
            m_n  = m_en ? (m_n + 1) % FRAME : 0;
            if (TOGGLE) begin
                m_en   = m_en ^ rise;
                m_prev = st_old;
            end else begin
                m_en = m_stable;
            end
        end
    end

    // ---------------- per-cycle checks ----------------
    bit chk_on = 1'b1;
    bit phase_on = 1'b0;
    bit p_lr = 0, p_sclk = 0, p_mclk = 0;
    bit lr_seen = 0;
    int sclk_rises = 0;
    int mclk_rises = 0;
    bit stable_seen = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("clocks", {29'd0, tx_lrclk, tx_sclk, tx_mclk}, {29'd0, exp_clocks(m_n)});
            chk("stable", {31'd0, dut.u_dbc.btn_stable}, {31'd0, m_stable});
        end
        if (phase_on) begin
            if (tx_lrclk != p_lr)
                chk("lr_on_sclk_fall", {30'd0, p_sclk, tx_sclk}, 32'd2);
            if (tx_sclk != p_sclk)
                chk("sclk_on_mclk_fall", {30'd0, p_mclk, tx_mclk}, 32'd2);
            if (tx_sclk && !p_sclk) sclk_rises++;
            if (tx_lrclk && !p_lr) begin
                if (lr_seen) chk("sclk_per_frame", sclk_rises, 64);
                lr_seen    = 1;
                sclk_rises = 0;
            end
        end
        if (tx_mclk && !p_mclk) mclk_rises++;
        if (dut.u_dbc.btn_stable) stable_seen = 1;
        p_lr   = tx_lrclk;
        p_sclk = tx_sclk;
        p_mclk = tx_mclk;
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int r0;
    int seg_len;

    initial begin
        // Reset held with the button pressed: nothing may propagate.
        btn     = 1'b1;
        reset_n = 1'b1;
        clocks(5);
        chk("reset_outputs", {29'd0, tx_lrclk, tx_sclk, tx_mclk}, 32'd0);
        btn = 1'b0;
        clocks(2);
        reset_n = 1'b0;
        clocks(3);

        // Press and hold: measure acceptance latency, then watch 3+ frames.
        btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (dut.u_dbc.btn_stable) begin
                lat = i;
                break;
            end
        end
        chk("dbc_latency", lat, DBC + 2);
        phase_on = 1'b1;
        clocks(3 * FRAME + 1100);
        phase_on = 1'b0;

        // Release while in the right channel.
        for (int i = 0; i < 2 * FRAME && !tx_lrclk; i++) clocks(1);
        chk("lr_wait", {31'd0, tx_lrclk}, 32'd1);
        btn = 1'b0;
        clocks(150);

        // Bounce train: no pulse is long enough to be accepted.
        stable_seen = 0;
        repeat (12) begin
            btn = 1'b1; clocks(50);
            btn = 1'b0; clocks(30);
        end
        clocks(200);
        chk("bounce_rejected", {31'd0, stable_seen}, 32'd0);

        // Random glitches and holds.
        for (int k = 0; k < 30; k++) begin
            btn     = 1'($urandom_range(0, 1));
            seg_len = $urandom_range(1, 250);
            clocks(seg_len);
        end

        // Asynchronous reset while running.
        btn = 1'b1;
        clocks(400 + $urandom_range(0, 300));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("async_rst", {29'd0, tx_lrclk, tx_sclk, tx_mclk}, 32'd0);
        btn = 1'b0;
        clocks(5);
        reset_n = 1'b0;
        clocks(5);

        // Two press/release cycles.
        btn = 1'b1; clocks(200);
        btn = 1'b0; clocks(100);
        r0 = mclk_rises;
        clocks(100);
        chk("run_after_release", {31'd0, (mclk_rises - r0) > 0}, {31'd0, TOGGLE});
        btn = 1'b1; clocks(200);
        btn = 1'b0; clocks(100);
        r0 = mclk_rises;
        clocks(100);
        chk("stop_after_2nd", mclk_rises - r0, 0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_clk_top.md
Name: i2s_clk_top

Overview:
- Top-level I2S transmit clock generator for a 100 MHz FPGA design.
- Derives the master clock (tx_mclk), bit clock (tx_sclk) and word-select clock (tx_lrclk) from the system clock using one free-running counter.
- The clocks are enabled or disabled by a debounced push-button (btn).
- Drives the clock pins of an external I2S DAC/codec.

Parameters:
- MCLK_LOG2, 3: tx_mclk = clk / 2^MCLK_LOG2 (12.5 MHz).
- SCLK_LOG2, 5: tx_sclk = clk / 2^SCLK_LOG2 (3.125 MHz, = mclk/4).
- LRCLK_LOG2, 11: tx_lrclk = clk / 2^LRCLK_LOG2 (48.828 kHz, 64 sclk per frame).
- DEBOUNCE_CYCLES, 1_000_000: clk cycles btn must be stable to be accepted (10 ms).
- Constraint: MCLK_LOG2 < SCLK_LOG2 < LRCLK_LOG2 and DEBOUNCE_CYCLES >= 2; violations are an elaboration error.

Ports:
- clk  in  1  100 MHz system clock.
- reset_n  in  1  reset, asynchronous, active-high.
- btn  in  1  raw push-button, asynchronous to clk, bouncy.
- tx_mclk  out  1  I2S master clock.
- tx_sclk  out  1  I2S bit clock.
- tx_lrclk  out  1  I2S word select; 0 = left, 1 = right.

Behaviour:
- Reset (reset_n=1):
  - Clears the synchronizer, debounce counter, debounced level, enable and divider counter.
  - All three outputs are 0 during and immediately after reset.
- btn path:
  - 2-FF synchronizer, then debouncer.
  - Debounce counter increments while the synchronized value differs from the stable level.
  - Counter clears whenever the synchronized value equals the stable level.
  - At count DEBOUNCE_CYCLES-1, the stable level takes the synchronized value and the counter clears.
  - Accepted-edge latency: 2 + DEBOUNCE_CYCLES clk cycles after a clean btn edge.
  - Glitches shorter than DEBOUNCE_CYCLES never change the stable level.
- Enable: en = debounced btn level (hold-to-run); see Optional Feature.
- Divider:
  - cnt is an unsigned LRCLK_LOG2-bit register.
  - While en=1, cnt increments by 1 every clk and wraps from all-ones to 0.
  - While en=0, cnt is held at 0.
- Outputs are combinational taps of the registered counter (glitch-free):
  - tx_mclk = cnt[MCLK_LOG2-1]
  - tx_sclk = cnt[SCLK_LOG2-1]
  - tx_lrclk = cnt[LRCLK_LOG2-1]
  - With en=0 all outputs are therefore 0.
- Phase rules:
  - tx_lrclk toggles only on the same clk edge as a tx_sclk falling edge (I2S-compliant).
  - Every tx_sclk edge coincides with a tx_mclk falling edge.
  - 1024 clk per lrclk half-period; 32 sclk per channel.
- en 0->1: counting starts from cnt=0.
  - First tx_mclk rise occurs 4 clk later.
  - First tx_sclk rise occurs 16 clk later.
  - First tx_lrclk rise occurs 1024 clk later.
- en 1->0 mid-frame: cnt clears on the next clk edge; all outputs are 0 from that edge on. No frame completion.
- Asynchronous reset mid-operation: outputs go to 0 immediately. Operation restarts from a clean state after release.

Optional Feature:
- Macro BTN_TOGGLE_EN.
- Defined: each accepted 0->1 transition of the debounced level toggles en; releases do nothing; en resets to 0.
- Undefined: en follows the debounced level directly (hold-to-run).

Decomposition:
- Package i2s_clk_pkg:
  - default divider exponents
  - derived counter width
  - DEBOUNCE_CYCLES default
  - localparam helper for debounce counter width ($clog2)
- Sub-module btn_debounce:
  - contains the synchronizer and debounce counter
  - inputs: clk, reset_n, btn_raw
  - output: btn_stable
- Top: instantiates btn_debounce and holds the enable logic and divider.

Test Plan:
- Reset: hold reset_n=1 for 5 clk with btn=1 -> all outputs 0; debounced level 0 throughout.
- Hold-to-run: DEBOUNCE_CYCLES=100; after reset release, btn=1 -> outputs stay 0 for 102 clk, then tx_mclk period 8 clk, tx_sclk 32 clk, tx_lrclk 2048 clk, all 50% duty.
- Phase check: over 3 full frames, every tx_lrclk edge coincides with a tx_sclk falling edge; 64 tx_sclk rises per tx_lrclk period.
- Bounce rejection: btn pulses of 50 clk high / 30 clk low for 1000 clk, then 0 -> en never asserts; outputs remain 0.
- Release mid-frame: btn=0 while tx_lrclk=1 -> after 102 clk, cnt clears and all outputs 0 within 1 further clk.
- BTN_TOGGLE_EN: press/release twice (each 200 clk) -> clocks run after first press and stay running through its release; they stop after the second press.
